// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the writeback arbiter and its result buffers.
package wb_arbiter_pkg;

  localparam int XLEN    = 32;
  localparam int RFIDX_W = 5;

  // Which source owns the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2,
    SRC_MDU  = 2'd3
  } wb_src_e;

  // One buffered writeback request.
  typedef struct packed {
    logic [RFIDX_W-1:0] rdidx;
    logic [XLEN-1:0]    wdata;
  } wb_entry_t;

  // Occupancy update for a 2-entry buffer; push and pop together keep the count.
  function automatic logic [1:0] fifo_cnt_next(input logic [1:0] cnt,
                                               input logic       push,
                                               input logic       pop);
    logic [1:0] nxt;
    case ({push, pop})
      2'b10:   nxt = cnt + 2'd1;
      2'b01:   nxt = cnt - 2'd1;
      default: nxt = cnt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry synchronous FIFO holding long-latency writeback results.
// Push is ignored when full and pop is ignored when empty, so a misbehaving
// neighbour can never corrupt the occupancy count.
module wb_fifo2
  import wb_arbiter_pkg::*;
#(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_nempty_nxt
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              push_s, pop_s;

  assign o_full       = (cnt_q == DEPTH[1:0]);
  assign o_empty      = (cnt_q == 2'd0);
  assign o_head       = mem_q[rd_ptr_q];
  assign o_nempty_nxt = (cnt_d != 2'd0);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    push_s   = i_push & ~o_full;
    pop_s    = i_pop & ~o_empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    cnt_d = fifo_cnt_next(cnt_q, push_s, pop_s);
  end

  // State register with synchronous flush.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU, LSU and MDU results onto the single
// register-file write port. The ALU always wins; buffered LSU/MDU results
// share the leftover cycles round-robin.
module wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int FIFO_DEPTH = 2   // only 2 is supported
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_alu_vld,
  input  logic [RFIDX_W-1:0] i_alu_rdidx,
  input  logic [XLEN-1:0]    i_alu_wdata,
  input  logic               i_lsu_vld,
  output logic               o_lsu_rdy,
  input  logic [RFIDX_W-1:0] i_lsu_rdidx,
  input  logic [XLEN-1:0]    i_lsu_wdata,
  input  logic               i_mdu_vld,
  output logic               o_mdu_rdy,
  input  logic [RFIDX_W-1:0] i_mdu_rdidx,
  input  logic [XLEN-1:0]    i_mdu_wdata,
  output logic               o_rdwen,
  output logic [RFIDX_W-1:0] o_rdidx,
  output logic [XLEN-1:0]    o_rd_wdata,
  output logic               o_busy
);

  localparam int EW = RFIDX_W + XLEN;

  logic [EW-1:0]      lsu_head_s, mdu_head_s;
  logic               lsu_full_s, lsu_empty_s, lsu_nempty_nxt_s;
  logic               mdu_full_s, mdu_empty_s, mdu_nempty_nxt_s;
  logic               lsu_push_s, mdu_push_s, lsu_pop_s, mdu_pop_s;
  wb_arbiter_pkg::wb_src_e grant_s;
  logic [RFIDX_W-1:0] sel_idx_s;
  logic [XLEN-1:0]    sel_data_s;

  logic               rr_q, rr_d;        // 0: LSU next on a tie, 1: MDU next
  logic               rdwen_q, rdwen_d;
  logic [RFIDX_W-1:0] rdidx_q, rdidx_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic               busy_q, busy_d;

  // Ready is derived from registered occupancy only: no vld->rdy path.
  assign o_lsu_rdy  = ~lsu_full_s;
  assign o_mdu_rdy  = ~mdu_full_s;
  assign lsu_push_s = i_lsu_vld & ~lsu_full_s;
  assign mdu_push_s = i_mdu_vld & ~mdu_full_s;

  assign o_rdwen    = rdwen_q;
  assign o_rdidx    = rdidx_q;
  assign o_rd_wdata = wdata_q;
  assign o_busy     = busy_q;

  wb_fifo2 #(.W(EW), .DEPTH(FIFO_DEPTH)) u_lsu_fifo (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_push       (lsu_push_s),
    .i_pop        (lsu_pop_s),
    .i_data       ({i_lsu_rdidx, i_lsu_wdata}),
    .o_head       (lsu_head_s),
    .o_full       (lsu_full_s),
    .o_empty      (lsu_empty_s),
    .o_nempty_nxt (lsu_nempty_nxt_s)
  );

  wb_fifo2 #(.W(EW), .DEPTH(FIFO_DEPTH)) u_mdu_fifo (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_push       (mdu_push_s),
    .i_pop        (mdu_pop_s),
    .i_data       ({i_mdu_rdidx, i_mdu_wdata}),
    .o_head       (mdu_head_s),
    .o_full       (mdu_full_s),
    .o_empty      (mdu_empty_s),
    .o_nempty_nxt (mdu_nempty_nxt_s)
  );

  // Grant selection, FIFO pops and next write-port values.
  always_comb begin
    grant_s    = wb_arbiter_pkg::SRC_NONE;
    rr_d       = rr_q;
    lsu_pop_s  = 1'b0;
    mdu_pop_s  = 1'b0;
    sel_idx_s  = rdidx_q;
    sel_data_s = wdata_q;

    if (i_alu_vld) begin
      grant_s = wb_arbiter_pkg::SRC_ALU;
    end else if (!lsu_empty_s && !mdu_empty_s) begin
      if (rr_q == 1'b0) begin
        grant_s = wb_arbiter_pkg::SRC_LSU;
      end else begin
        grant_s = wb_arbiter_pkg::SRC_MDU;
      end
    end else if (!lsu_empty_s) begin
      grant_s = wb_arbiter_pkg::SRC_LSU;
    end else if (!mdu_empty_s) begin
      grant_s = wb_arbiter_pkg::SRC_MDU;
    end else begin
      grant_s = wb_arbiter_pkg::SRC_NONE;
    end

    case (grant_s)
      wb_arbiter_pkg::SRC_ALU: begin
        sel_idx_s  = i_alu_rdidx;
        sel_data_s = i_alu_wdata;
      end
      wb_arbiter_pkg::SRC_LSU: begin
        sel_idx_s  = lsu_head_s[XLEN +: RFIDX_W];
        sel_data_s = lsu_head_s[XLEN-1:0];
        lsu_pop_s  = 1'b1;
        rr_d       = 1'b1;
      end
      wb_arbiter_pkg::SRC_MDU: begin
        sel_idx_s  = mdu_head_s[XLEN +: RFIDX_W];
        sel_data_s = mdu_head_s[XLEN-1:0];
        mdu_pop_s  = 1'b1;
        rr_d       = 1'b0;
      end
      default: begin
        sel_idx_s  = rdidx_q;
        sel_data_s = wdata_q;
      end
    endcase

    // x0 writes consume the grant but never enable the register file.
    rdwen_d = (grant_s != wb_arbiter_pkg::SRC_NONE) && (sel_idx_s != {RFIDX_W{1'b0}});
    rdidx_d = sel_idx_s;
    wdata_d = sel_data_s;
    busy_d  = lsu_nempty_nxt_s | mdu_nempty_nxt_s | rdwen_d;
  end

  // Registered write port, busy flag and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      rr_q    <= 1'b0;
      rdwen_q <= 1'b0;
      rdidx_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      rdwen_q <= rdwen_d;
      rdidx_q <= rdidx_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        alu_vld, lsu_vld, mdu_vld;
  logic [4:0]  alu_idx, lsu_idx, mdu_idx;
  logic [31:0] alu_dat, lsu_dat, mdu_dat;
  logic        lsu_rdy, mdu_rdy, rdwen, busy;
  logic [4:0]  rdidx;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(32), .RFIDX_W(5), .FIFO_DEPTH(2)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_alu_vld   (alu_vld),
    .i_alu_rdidx (alu_idx),
    .i_alu_wdata (alu_dat),
    .i_lsu_vld   (lsu_vld),
    .o_lsu_rdy   (lsu_rdy),
    .i_lsu_rdidx (lsu_idx),
    .i_lsu_wdata (lsu_dat),
    .i_mdu_vld   (mdu_vld),
    .o_mdu_rdy   (mdu_rdy),
    .i_mdu_rdidx (mdu_idx),
    .i_mdu_wdata (mdu_dat),
    .o_rdwen     (rdwen),
    .o_rdidx     (rdidx),
    .o_rd_wdata  (wdata),
    .o_busy      (busy)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_vld = 1'b0; alu_idx = 5'd0; alu_dat = 32'd0;
    lsu_vld = 1'b0; lsu_idx = 5'd0; lsu_dat = 32'd0;
    mdu_vld = 1'b0; mdu_idx = 5'd0; mdu_dat = 32'd0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    idle_inputs();
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (rdwen !== 1'b0) begin errors++; $display("FAIL reset_rdwen got %0h exp 0", rdwen); end
    checks++; if (rdidx !== 5'd0) begin errors++; $display("FAIL reset_rdidx got %0h exp 0", rdidx); end
    checks++; if (wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %0h exp 0", wdata); end
    checks++; if (lsu_rdy !== 1'b1) begin errors++; $display("FAIL reset_lsu_rdy got %0h exp 1", lsu_rdy); end
    checks++; if (mdu_rdy !== 1'b1) begin errors++; $display("FAIL reset_mdu_rdy got %0h exp 1", mdu_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
  endtask

  task automatic test_alu();
    alu_vld = 1'b1; alu_idx = 5'd5; alu_dat = 32'h0000_1234;
    step();
    idle_inputs();
    checks++; if (rdwen !== 1'b1) begin errors++; $display("FAIL alu_rdwen got %0h exp 1", rdwen); end
    checks++; if (rdidx !== 5'd5) begin errors++; $display("FAIL alu_rdidx got %0h exp 5", rdidx); end
    checks++; if (wdata !== 32'h0000_1234) begin errors++; $display("FAIL alu_wdata got %0h exp 1234", wdata); end
    step();
    checks++; if (rdwen !== 1'b0) begin errors++; $display("FAIL alu_rdwen_drop got %0h exp 0", rdwen); end
    checks++; if (wdata !== 32'h0000_1234) begin errors++; $display("FAIL alu_wdata_hold got %0h exp 1234", wdata); end
  endtask

  task automatic test_lsu();
    lsu_vld = 1'b1; lsu_idx = 5'd10; lsu_dat = 32'hDEAD_BEEF;
    checks++; if (lsu_rdy !== 1'b1) begin errors++; $display("FAIL lsu_rdy_pre got %0h exp 1", lsu_rdy); end
    step();
    idle_inputs();
    checks++; if (rdwen !== 1'b0) begin errors++; $display("FAIL lsu_early_rdwen got %0h exp 0", rdwen); end
    checks++; if (lsu_rdy !== 1'b1) begin errors++; $display("FAIL lsu_rdy_mid got %0h exp 1", lsu_rdy); end
    step();
    checks++; if (rdwen !== 1'b1) begin errors++; $display("FAIL lsu_rdwen got %0h exp 1", rdwen); end
    checks++; if (rdidx !== 5'd10) begin errors++; $display("FAIL lsu_rdidx got %0h exp a", rdidx); end
    checks++; if (wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lsu_wdata got %0h exp deadbeef", wdata); end
    checks++; if (lsu_rdy !== 1'b1) begin errors++; $display("FAIL lsu_rdy_post got %0h exp 1", lsu_rdy); end
    step();
    checks++; if (rdwen !== 1'b0) begin errors++; $display("FAIL lsu_rdwen_drop got %0h exp 0", rdwen); end
  endtask

  task automatic test_back_to_back();
    alu_vld = 1'b1; alu_idx = 5'd1; alu_dat = 32'h0000_0101;
    lsu_vld = 1'b1; lsu_idx = 5'd11; lsu_dat = 32'h0000_0A11;
    step();
    checks++; if (rdidx !== 5'd1 || rdwen !== 1'b1) begin errors++; $display("FAIL bp_alu1 got idx %0h en %0h exp 1/1", rdidx, rdwen); end
    checks++; if (lsu_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_after1 got %0h exp 1", lsu_rdy); end
    alu_idx = 5'd2; alu_dat = 32'h0000_0102;
    lsu_idx = 5'd12; lsu_dat = 32'h0000_0A12;
    step();
    checks++; if (rdidx !== 5'd2) begin errors++; $display("FAIL bp_alu2 got %0h exp 2", rdidx); end
    checks++; if (lsu_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_full got %0h exp 0", lsu_rdy); end
    alu_idx = 5'd3; alu_dat = 32'h0000_0103;
    lsu_idx = 5'd13; lsu_dat = 32'h0000_0A13;
    step();
    checks++; if (rdidx !== 5'd3) begin errors++; $display("FAIL bp_alu3 got %0h exp 3", rdidx); end
    checks++; if (lsu_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_held got %0h exp 0", lsu_rdy); end
    alu_idx = 5'd4; alu_dat = 32'h0000_0104;
    step();
    checks++; if (rdidx !== 5'd4 || wdata !== 32'h0000_0104) begin errors++; $display("FAIL bp_alu4 got %0h/%0h exp 4/104", rdidx, wdata); end
    alu_vld = 1'b0;
    step();
    checks++; if (rdwen !== 1'b1 || rdidx !== 5'd11 || wdata !== 32'h0000_0A11) begin errors++; $display("FAIL bp_lsu1 got %0h/%0h/%0h exp 1/b/a11", rdwen, rdidx, wdata); end
    checks++; if (lsu_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_free got %0h exp 1", lsu_rdy); end
    step();
    lsu_vld = 1'b0;
    checks++; if (rdwen !== 1'b1 || rdidx !== 5'd12 || wdata !== 32'h0000_0A12) begin errors++; $display("FAIL bp_lsu2 got %0h/%0h/%0h exp 1/c/a12", rdwen, rdidx, wdata); end
    step();
    checks++; if (rdwen !== 1'b1 || rdidx !== 5'd13 || wdata !== 32'h0000_0A13) begin errors++; $display("FAIL bp_lsu3 got %0h/%0h/%0h exp 1/d/a13", rdwen, rdidx, wdata); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_hi got %0h exp 1", busy); end
    step();
    checks++; if (rdwen !== 1'b0) begin errors++; $display("FAIL bp_drain_rdwen got %0h exp 0", rdwen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_lo got %0h exp 0", busy); end
    idle_inputs();
  endtask

  task automatic test_x0();
    alu_vld = 1'b1; alu_idx = 5'd0; alu_dat = 32'h0000_FFFF;
    step();
    idle_inputs();
    checks++; if (rdwen !== 1'b0) begin errors++; $display("FAIL x0_rdwen got %0h exp 0", rdwen); end
    checks++; if (rdidx !== 5'd0) begin errors++; $display("FAIL x0_rdidx got %0h exp 0", rdidx); end
    checks++; if (wdata !== 32'h0000_FFFF) begin errors++; $display("FAIL x0_wdata got %0h exp ffff", wdata); end
    step();
  endtask

  task automatic test_round_robin();
    logic [4:0]  exp_idx [4];
    logic [31:0] exp_dat [4];
    exp_idx[0] = 5'd1; exp_idx[1] = 5'd2; exp_idx[2] = 5'd3; exp_idx[3] = 5'd4;
    exp_dat[0] = 32'hAAAA_0001; exp_dat[1] = 32'hBBBB_0002;
    exp_dat[2] = 32'hAAAA_0003; exp_dat[3] = 32'hBBBB_0004;
    apply_reset();
    lsu_vld = 1'b1; lsu_idx = 5'd1; lsu_dat = 32'hAAAA_0001;
    mdu_vld = 1'b1; mdu_idx = 5'd2; mdu_dat = 32'hBBBB_0002;
    step();
    lsu_idx = 5'd3; lsu_dat = 32'hAAAA_0003;
    mdu_idx = 5'd4; mdu_dat = 32'hBBBB_0004;
    checks++; if (mdu_rdy !== 1'b1) begin errors++; $display("FAIL rr_mdu_rdy got %0h exp 1", mdu_rdy); end
    step();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rdwen !== 1'b1 || rdidx !== exp_idx[k] || wdata !== exp_dat[k]) begin
        errors++;
        $display("FAIL rr_grant%0d got %0h/%0h/%0h exp 1/%0h/%0h", k, rdwen, rdidx, wdata, exp_idx[k], exp_dat[k]);
      end
      step();
    end
    checks++; if (rdwen !== 1'b0) begin errors++; $display("FAIL rr_done_rdwen got %0h exp 0", rdwen); end
  endtask

  task automatic test_reset_flush();
    alu_vld = 1'b1; alu_idx = 5'd9; alu_dat = 32'h0000_0909;
    lsu_vld = 1'b1; lsu_idx = 5'd7; lsu_dat = 32'h0000_0707;
    step();
    lsu_idx = 5'd8; lsu_dat = 32'h0000_0808;
    step();
    checks++; if (lsu_rdy !== 1'b0) begin errors++; $display("FAIL flush_pre_full got %0h exp 0", lsu_rdy); end
    idle_inputs();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    checks++; if (rdwen !== 1'b0) begin errors++; $display("FAIL flush_rst_rdwen got %0h exp 0", rdwen); end
    checks++; if (lsu_rdy !== 1'b1) begin errors++; $display("FAIL flush_lsu_rdy got %0h exp 1", lsu_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %0h exp 0", busy); end
    step();
    checks++; if (rdwen !== 1'b0) begin errors++; $display("FAIL flush_after1 got %0h exp 0", rdwen); end
    step();
    checks++; if (rdwen !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_after2 got en %0h busy %0h exp 0/0", rdwen, busy); end
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    test_reset();
    test_alu();
    test_lsu();
    test_back_to_back();
    test_x0();
    test_round_robin();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-stage arbiter sitting directly upstream of the general-purpose register file; it drives the register file's single write port (write enable, destination index, write data).
- Merges results from three execution sources into at most one register write per cycle:
  - the single-cycle ALU, which cannot be back-pressured;
  - the LSU, load data, valid/ready handshake;
  - the MDU, multiply/divide, valid/ready handshake.
- Long-latency results are buffered in small FIFOs so the LSU and MDU can retire without stalling while the ALU owns the port.

Parameters:
- XLEN, 32, data width of the write data.
- RFIDX_W, 5, register index width.
- FIFO_DEPTH, 2, entries per long-latency source buffer; only 2 is supported.

Ports:
- i_clk  input  1  core clock.
- i_rstn  input  1  synchronous active-low reset.
- i_alu_vld  input  1  ALU result valid; always accepted.
- i_alu_rdidx  input  RFIDX_W  ALU destination index.
- i_alu_wdata  input  XLEN  ALU result.
- i_lsu_vld  input  1  LSU result valid.
- o_lsu_rdy  output  1  LSU buffer can accept.
- i_lsu_rdidx  input  RFIDX_W  LSU destination index.
- i_lsu_wdata  input  XLEN  load data.
- i_mdu_vld  input  1  MDU result valid.
- o_mdu_rdy  output  1  MDU buffer can accept.
- i_mdu_rdidx  input  RFIDX_W  MDU destination index.
- i_mdu_wdata  input  XLEN  MDU result.
- o_rdwen  output  1  register-file write enable (registered).
- o_rdidx  output  RFIDX_W  register-file write index (registered).
- o_rd_wdata  output  XLEN  register-file write data (registered).
- o_busy  output  1  either buffer non-empty or o_rdwen high.

Behaviour:
- Clocking and reset:
  - One clock, i_clk; synchronous active-low reset, i_rstn.
  - All state updates on posedge i_clk.
- Reset values:
  - o_rdwen=0, o_rdidx=0, o_rd_wdata=0.
  - Both FIFOs empty, so o_lsu_rdy=1 and o_mdu_rdy=1 (after reset only).
  - o_busy=0; round-robin pointer = LSU.
- Reset during operation: i_rstn=0 flushes both FIFOs and drops any in-flight write; no write is issued in the cycle following reset.
- Handshake:
  - A transfer occurs on a cycle where vld & rdy are both high.
  - rdy = (fifo count < 2) and depends only on registered count; there is no combinational vld->rdy path.
  - Sources must hold index and data stable while vld is high and rdy is low.
- Buffering:
  - Each long-latency source pushes {rdidx, wdata} into its own 2-entry FIFO.
  - Push and pop in the same cycle at count 1 leaves count 1; at count 0 with push only, count becomes 1.
  - Pushing at count 2 is impossible, since rdy=0.
  - Pop at count 0 is never generated.
- Arbitration, evaluated each cycle:
  - If i_alu_vld, the ALU is granted.
  - Otherwise, if both FIFOs are non-empty, grant by round-robin; the pointer toggles to the other source after each FIFO grant.
  - Otherwise, grant whichever FIFO is non-empty.
  - A FIFO is popped only when granted.
- Output stage:
  - The granted entry is registered into o_rdidx/o_rd_wdata.
  - o_rdwen = granted & (rdidx != 0).
- Latency:
  - ALU result appears on the write port exactly 1 cycle after i_alu_vld.
  - LSU/MDU result appears at the earliest 2 cycles after handshake: cycle N push, N+1 head/grant, N+2 o_rdwen.
- Index 0:
  - Writes to x0 are consumed (FIFO popped, grant used) but o_rdwen stays 0; o_rdidx/o_rd_wdata still update.
- When no grant: o_rdwen=0; o_rdidx/o_rd_wdata hold their previous values.
- Starvation: continuous ALU traffic may starve the FIFOs. The issue stage is responsible for bubbles; this block makes no forward-progress guarantee under 100% ALU load.
- o_busy is registered: (lsu count != 0) | (mdu count != 0) | o_rdwen, as seen on the next cycle.

Decomposition:
- Shared package holds:
  - XLEN, RFIDX_W constants;
  - source-select encoding SRC_NONE=2'd0, SRC_ALU=2'd1, SRC_LSU=2'd2, SRC_MDU=2'd3;
  - wb entry struct {rdidx, wdata}.
- One sub-module, wb_fifo2: a 2-entry synchronous FIFO with push/pop/full/empty/head and the same clock/reset. It is instantiated twice, once for LSU and once for MDU.

Test Plan:
- Reset, then a single ALU result (rdidx=5, wdata=0x1234) -> next cycle o_rdwen=1, o_rdidx=5, o_rd_wdata=0x1234; following cycle o_rdwen=0.
- LSU handshake (rdidx=10, 0xDEADBEEF) with ALU idle -> o_rdwen=1 with those values exactly 2 cycles later; o_lsu_rdy stays 1.
- ALU valid every cycle for 4 cycles, plus 3 LSU pushes -> o_lsu_rdy drops after the 2nd push; the 3rd push is held until ALU goes idle; LSU writes then appear in order.
- LSU and MDU both buffered, ALU idle -> grants alternate LSU, MDU, LSU, MDU; first grant after reset goes to LSU.
- ALU result to rdidx=0 with wdata=0xFFFF -> o_rdwen stays 0 on the next cycle.
- Two LSU entries buffered, i_rstn=0 for one cycle -> both dropped, no o_rdwen afterwards, o_lsu_rdy=1, o_busy=0.
